lag_capture: RTL and testbench
==============================

Name: lag_capture

Overview:
- Single-shot latency capture stage; sits between the frame-start reset pulse and the min/max/average statistics logic.
- Each measurement window opens when reset_bcdcounter is released. The block counts elapsed microseconds from a clock prescaler.
- On the first sensor rising edge in the window, it captures the binary latency, then converts it to packed BCD with a sequential double-dabble.
- If no edge arrives before MAX_COUNT, it flags timeout.

Parameters:
- CLOCK_DIVIDER, 27: clock cycles per microsecond tick (27 MHz input).
- COUNT_WIDTH, 20: width of binary microsecond counter; must hold MAX_COUNT.
- MAX_COUNT, 999999: saturation/timeout value in microseconds.
- BCD_DIGITS, 6: packed BCD output digits (4*BCD_DIGITS bits).

Ports:
- clock  in  1  system clock, 27 MHz.
- reset_bcdcounter  in  1  asynchronous, active-high reset; release starts a new window.
- enable  in  1  when 0, tick counting and edge acceptance pause.
- sensor_n  in  1  raw photo-sensor input, active-low, asynchronous.
- us_count  out  COUNT_WIDTH  live elapsed microseconds.
- sample_us  out  COUNT_WIDTH  captured latency, binary.
- sample_valid  out  1  one-cycle pulse when sample_us is loaded.
- sample_bcd  out  4*BCD_DIGITS  captured latency, packed BCD.
- bcd_valid  out  1  one-cycle pulse when sample_bcd is updated.
- timeout  out  1  sticky until reset; no edge seen within MAX_COUNT.
- busy  out  1  high in states ARMED and CONVERT.

Behaviour:
- Reset values (asynchronous, applied immediately):
  - state = ARMED; prescaler = 0.
  - us_count, sample_us, sample_bcd = 0.
  - sample_valid, bcd_valid, timeout = 0; busy = 1.
  - Both sensor sync flops and the edge-detect prev register = 1 (active), so a sensor already active at reset release produces no edge.
- Sensor path:
  - sensor_in = ~sensor_n passes through 2 synchroniser flops.
  - rise = sync_out & ~prev.
  - Latency from pin to rise is 2–3 clocks; this is not compensated.
- Prescaler:
  - Active only in ARMED with enable=1. Counts 0..CLOCK_DIVIDER-1 and wraps.
  - tick = (prescaler == CLOCK_DIVIDER-1).
  - On tick, us_count increments by 1.
- States:
  - ARMED:
    - If enable && rise in cycle N: sample_us <= us_count (value before any same-cycle increment); sample_valid = 1 in cycle N+1 only; go CONVERT; us_count freezes.
    - Else if enable && tick && us_count == MAX_COUNT: timeout <= 1; sample_us <= MAX_COUNT; sample_bcd <= all nines; bcd_valid pulses 1 cycle (N+1); go TIMEOUT.
    - rise and timeout condition in the same cycle: the edge wins (capture of MAX_COUNT).
    - us_count never exceeds MAX_COUNT.
  - CONVERT:
    - Double-dabble, one bit per clock, COUNT_WIDTH iterations.
    - Each iteration: add 3 to every BCD nibble >= 5, then shift left, inserting the binary MSB.
    - After the final iteration: sample_bcd loaded; bcd_valid = 1 for exactly one cycle at N+1+COUNT_WIDTH (N+21 with defaults); go DONE.
    - sample_bcd holds its previous value during conversion (no partial results visible).
  - DONE, TIMEOUT:
    - Terminal states; all outputs hold; further edges are ignored.
    - Exit only via reset.
- Edges in CONVERT, DONE or TIMEOUT are ignored and never queued.
- enable=0:
  - Freezes the prescaler and us_count and masks rise in ARMED.
  - Has no effect on an in-progress CONVERT.
- Reset mid-CONVERT aborts the conversion: no bcd_valid, all outputs return to reset values.
- Reset held high: busy = 1, no counting.
- Arithmetic:
  - us_count and sample_us are unsigned.
  - The BCD is exact for values 0..10^BCD_DIGITS-1; MAX_COUNT must be within this range.

Test Plan:
- Release reset, enable=1, assert sensor_n low after 27*1234 clocks → sample_valid pulse, sample_us=1234; 20 clocks later bcd_valid pulse, sample_bcd=24'h001234; state DONE, busy=0.
- sensor_n low before reset release, held low → no capture. Deassert then reassert sensor_n at 27*50 clocks → sample_us=50.
- MAX_COUNT=100, no sensor edge → after 27*101 clocks: timeout=1, bcd_valid pulse, sample_bcd=24'h999999, sample_us=100, us_count=100; later edges ignored.
- enable=0 for 27*10 clocks mid-window, then edge at total 27*40 clocks → sample_us=30.
- Capture 999999 (force via MAX_COUNT edge-wins case) → sample_bcd=24'h999999. Capture 0 (edge 3 clocks after reset) → sample_bcd=24'h000000.
- Assert reset 10 clocks into CONVERT → no bcd_valid, all outputs 0, busy=1. New window after release → a fresh capture succeeds.

Source files
------------

// File: rtl/lag_capture.sv
// -----------------------------------------------------------------------------
// lag_capture
//   Single-shot latency capture. A measurement window opens when
//   reset_bcdcounter is released. The block then counts elapsed microseconds
//   (one tick every CLOCK_DIVIDER clocks). The first synchronised rising edge
//   of the active-low sensor captures the count. A serial double-dabble then
//   converts the count to packed BCD. If the count sits at MAX_COUNT for a
//   further full microsecond without an edge, the window times out.
//
// Ports
//   clock            in   system clock (27 MHz nominal)
//   reset_bcdcounter in   asynchronous active-high reset; release opens a window
//   enable           in   0 pauses tick counting and edge acceptance
//   sensor_n         in   raw active-low photo-sensor input (asynchronous)
//   us_count         out  live elapsed microseconds
//   sample_us        out  captured latency, binary
//   sample_valid     out  one-cycle pulse when sample_us is loaded
//   sample_bcd       out  captured latency, packed BCD
//   bcd_valid        out  one-cycle pulse when sample_bcd is updated
//   timeout          out  sticky: no edge seen within MAX_COUNT
//   busy             out  high while armed or converting
// -----------------------------------------------------------------------------
module lag_capture #(
    parameter int CLOCK_DIVIDER = 27,
    parameter int COUNT_WIDTH   = 20,
    parameter int MAX_COUNT     = 999999,
    parameter int BCD_DIGITS    = 6
) (
    input  logic                      clock,
    input  logic                      reset_bcdcounter,
    input  logic                      enable,
    input  logic                      sensor_n,
    output logic [COUNT_WIDTH-1:0]    us_count,
    output logic [COUNT_WIDTH-1:0]    sample_us,
    output logic                      sample_valid,
    output logic [4*BCD_DIGITS-1:0]   sample_bcd,
    output logic                      bcd_valid,
    output logic                      timeout,
    output logic                      busy
);

    localparam int PRESC_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int ITER_W  = $clog2(COUNT_WIDTH + 1);
    localparam int BCD_W   = 4 * BCD_DIGITS;

    localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(CLOCK_DIVIDER - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [ITER_W-1:0]      ITER_LAST  = ITER_W'(COUNT_WIDTH - 1);
    localparam logic [BCD_W-1:0]       ALL_NINES  = {BCD_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_ARMED   = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_prev;
    logic [PRESC_W-1:0]     r_presc;
    logic [COUNT_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [ITER_W-1:0]      r_iter;

    logic                   w_rise;
    logic                   w_tick;
    logic                   w_armed_en;
    logic                   w_capture;
    logic                   w_expire;
    logic                   w_last_iter;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BCD_W-1:0]       w_bcd_step;

    // Sensor synchroniser. Flops reset to "active" so that a sensor already
    // active when the window opens does not look like a fresh edge.
    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= ~sensor_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_armed_en  = (r_state == S_ARMED) && enable;
    assign w_tick      = (r_presc == PRESC_LAST);
    // An edge in the same cycle as the expiry condition takes priority.
    assign w_capture   = w_armed_en && w_rise;
    assign w_expire    = w_armed_en && !w_rise && w_tick && (us_count == COUNT_MAX);
    assign w_last_iter = (r_state == S_CONVERT) && (r_iter == ITER_LAST);

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next
    // binary MSB.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_nibble
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                        ? r_bcd[4*gi +: 4] + 4'd3
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_bcd_step = BCD_W'({w_bcd_adj, r_bin[COUNT_WIDTH-1]});

    // State register
    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            r_state <= S_ARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ARMED: begin
                if (w_capture) begin
                    w_state_next = S_CONVERT;
                end else if (w_expire) begin
                    w_state_next = S_TIMEOUT;
                end
            end
            S_CONVERT: begin
                if (w_last_iter) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // State-derived outputs
    always_comb begin
        busy = (r_state == S_ARMED) || (r_state == S_CONVERT);
    end

    // Counting, capture and conversion datapath
    always_ff @(posedge clock or posedge reset_bcdcounter) begin
        if (reset_bcdcounter) begin
            r_presc      <= '0;
            us_count     <= '0;
            sample_us    <= '0;
            sample_valid <= 1'b0;
            sample_bcd   <= '0;
            bcd_valid    <= 1'b0;
            timeout      <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_iter       <= '0;
        end else begin
            sample_valid <= 1'b0;
            bcd_valid    <= 1'b0;

            // Counting stops in the capture cycle so us_count shows the
            // captured value from then on.
            if (w_armed_en && !w_capture) begin
                r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
                if (w_tick && (us_count != COUNT_MAX)) begin
                    us_count <= us_count + COUNT_WIDTH'(1);
                end
            end

            if (w_capture) begin
                sample_us    <= us_count;
                sample_valid <= 1'b1;
                r_bin        <= us_count;
                r_bcd        <= '0;
                r_iter       <= '0;
            end else if (w_expire) begin
                timeout    <= 1'b1;
                sample_us  <= COUNT_MAX;
                sample_bcd <= ALL_NINES;
                bcd_valid  <= 1'b1;
            end

            // sample_bcd is only written once the final iteration is done,
            // so partial results never appear on the output.
            if (r_state == S_CONVERT) begin
                r_bin  <= r_bin << 1;
                r_bcd  <= w_bcd_step;
                r_iter <= r_iter + ITER_W'(1);
                if (w_last_iter) begin
                    sample_bcd <= w_bcd_step;
                    bcd_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lag_capture.sv
// -----------------------------------------------------------------------------
// tb_lag_capture
//   Two instances: dut_a uses the default parameters and dut_b uses
//   MAX_COUNT=100. A behavioural model tracks enabled cycles since release and
//   delays the sensor by the synchroniser depth. It derives every output from
//   those quantities, and the outputs of both instances are compared against
//   it on every falling edge. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_lag_capture;

    localparam int DIV  = 27;
    localparam int CW   = 20;
    localparam int BD   = 6;
    localparam int BW   = 24;
    localparam int MAXA = 999999;
    localparam int MAXB = 100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst [2];
    logic          en  [2];
    logic          sn  [2];
    logic [CW-1:0] usc [2];
    logic [CW-1:0] sus [2];
    logic          sv  [2];
    logic [BW-1:0] sbcd[2];
    logic          bv  [2];
    logic          to  [2];
    logic          bz  [2];

    int n_checks = 0;
    int n_pass   = 0;

    lag_capture dut_a (
        .clock            (clock),
        .reset_bcdcounter (rst[0]),
        .enable           (en[0]),
        .sensor_n         (sn[0]),
        .us_count         (usc[0]),
        .sample_us        (sus[0]),
        .sample_valid     (sv[0]),
        .sample_bcd       (sbcd[0]),
        .bcd_valid        (bv[0]),
        .timeout          (to[0]),
        .busy             (bz[0])
    );

    lag_capture #(.MAX_COUNT(MAXB)) dut_b (
        .clock            (clock),
        .reset_bcdcounter (rst[1]),
        .enable           (en[1]),
        .sensor_n         (sn[1]),
        .us_count         (usc[1]),
        .sample_us        (sus[1]),
        .sample_valid     (sv[1]),
        .sample_bcd       (sbcd[1]),
        .bcd_valid        (bv[1]),
        .timeout          (to[1]),
        .busy             (bz[1])
    );

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, inst, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < BD; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    int            maxc [2];
    int            en_cyc[2];
    int            age  [2];
    bit            armed[2];
    bit            conv [2];
    bit            h0[2], h1[2], h2[2];
    int            e_us [2];
    int            e_sus[2];
    bit            e_sv [2];
    bit            e_bv [2];
    bit            e_to [2];
    logic [BW-1:0] e_bcd[2];

    initial begin
        maxc[0] = MAXA;
        maxc[1] = MAXB;
    end

    always @(posedge clock) begin
        bit rise;
        int cur;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                en_cyc[i] = 0; age[i] = 0; armed[i] = 1'b1; conv[i] = 1'b0;
                h0[i] = 1'b1; h1[i] = 1'b1; h2[i] = 1'b1;
                e_us[i] = 0; e_sus[i] = 0; e_sv[i] = 1'b0; e_bv[i] = 1'b0;
                e_to[i] = 1'b0; e_bcd[i] = '0;
            end else begin
                rise = h1[i] & ~h2[i];
                e_sv[i] = 1'b0;
                e_bv[i] = 1'b0;
                if (armed[i]) begin
                    if (en[i]) begin
                        cur = en_cyc[i] / DIV;
                        if (cur > maxc[i]) cur = maxc[i];
                        if (rise) begin
                            e_sus[i] = cur; e_sv[i] = 1'b1;
                            armed[i] = 1'b0; conv[i] = 1'b1; age[i] = 0;
                        end else if (en_cyc[i] + 1 == DIV * (maxc[i] + 1)) begin
                            e_to[i] = 1'b1; e_sus[i] = maxc[i];
                            e_bcd[i] = 24'h999999; e_bv[i] = 1'b1;
                            armed[i] = 1'b0;
                        end else begin
                            en_cyc[i]++;
                        end
                    end
                end else if (conv[i]) begin
                    age[i]++;
                    if (age[i] == CW) begin
                        e_bcd[i] = to_bcd(e_sus[i]);
                        e_bv[i]  = 1'b1;
                        conv[i]  = 1'b0;
                    end
                end
                e_us[i] = en_cyc[i] / DIV;
                if (e_us[i] > maxc[i]) e_us[i] = maxc[i];
                h2[i] = h1[i];
                h1[i] = h0[i];
                h0[i] = ~sn[i];
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            check("us_count",     i, 32'(usc[i]),  32'(e_us[i]));
            check("sample_us",    i, 32'(sus[i]),  32'(e_sus[i]));
            check("sample_valid", i, 32'(sv[i]),   32'(e_sv[i]));
            check("sample_bcd",   i, 32'(sbcd[i]), 32'(e_bcd[i]));
            check("bcd_valid",    i, 32'(bv[i]),   32'(e_bv[i]));
            check("timeout",      i, 32'(to[i]),   32'(e_to[i]));
            check("busy",         i, 32'(bz[i]),   32'(armed[i] | conv[i]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    function automatic bit sig(input int i, input int which);
        case (which)
            0:       return sv[i];
            1:       return bv[i];
            default: return to[i];
        endcase
    endfunction

    task automatic wait_sig(input int i, input int which, input int budget, output int cyc);
        cyc = 0;
        while (!sig(i, which) && cyc < budget) begin
            step(1);
            cyc++;
        end
        check("wait_bound", i, 32'(sig(i, which)), 32'd1);
    endtask

    task automatic open_window(input int i);
        rst[i] = 1'b1;
        sn[i]  = 1'b1;
        en[i]  = 1'b1;
        step(2);
        rst[i] = 1'b0;
    endtask

    initial begin
        int c;
        rst[0] = 1'b1; rst[1] = 1'b1;
        en[0]  = 1'b1; en[1]  = 1'b1;
        sn[0]  = 1'b1; sn[1]  = 1'b1;
        step(3);

        // 1: edge after 27*1234 clocks
        rst[0] = 1'b0;
        step(DIV * 1234);
        check("t1_live_count", 0, 32'(usc[0]), 32'd1234);
        sn[0] = 1'b0;
        wait_sig(0, 0, 10, c);
        check("t1_sample_us", 0, 32'(sus[0]), 32'd1234);
        wait_sig(0, 1, 40, c);
        check("t1_bcd_latency", 0, 32'(c), 32'd20);
        check("t1_sample_bcd", 0, 32'(sbcd[0]), 32'h001234);
        check("t1_busy", 0, 32'(bz[0]), 32'd0);
        $display("tb: capture sample_us=%0d sample_bcd=%h", sus[0], sbcd[0]);
        sn[0] = 1'b1; step(5); sn[0] = 1'b0; step(10);
        check("t1_edge_ignored", 0, 32'(sus[0]), 32'd1234);

        // 2: sensor already active at release
        rst[0] = 1'b1; sn[0] = 1'b0;
        step(3);
        rst[0] = 1'b0;
        step(DIV * 40);
        check("t2_no_capture", 0, 32'(bz[0]), 32'd1);
        check("t2_count40", 0, 32'(usc[0]), 32'd40);
        sn[0] = 1'b1;
        step(DIV * 10);
        sn[0] = 1'b0;
        wait_sig(0, 0, 10, c);
        check("t2_sample_us", 0, 32'(sus[0]), 32'd50);
        wait_sig(0, 1, 40, c);
        check("t2_sample_bcd", 0, 32'(sbcd[0]), 32'h000050);
        $display("tb: capture sample_us=%0d sample_bcd=%h", sus[0], sbcd[0]);

        // 3: timeout on dut_b (MAX_COUNT=100)
        open_window(1);
        step(DIV * 101 - 1);
        check("t3_not_yet", 1, 32'(to[1]), 32'd0);
        check("t3_sat_count", 1, 32'(usc[1]), 32'd100);
        step(1);
        check("t3_timeout", 1, 32'(to[1]), 32'd1);
        check("t3_bcd_valid", 1, 32'(bv[1]), 32'd1);
        check("t3_sample_bcd", 1, 32'(sbcd[1]), 32'h999999);
        check("t3_sample_us", 1, 32'(sus[1]), 32'd100);
        check("t3_busy", 1, 32'(bz[1]), 32'd0);
        $display("tb: timeout sample_us=%0d sample_bcd=%h", sus[1], sbcd[1]);
        sn[1] = 1'b0;
        step(10);
        check("t3_edge_ignored", 1, 32'(sus[1]), 32'd100);
        check("t3_sticky", 1, 32'(to[1]), 32'd1);

        // 4: enable low for 27*10 clocks mid-window
        open_window(0);
        step(DIV * 15);
        en[0] = 1'b0;
        step(DIV * 10);
        check("t4_frozen", 0, 32'(usc[0]), 32'd15);
        en[0] = 1'b1;
        step(DIV * 15);
        sn[0] = 1'b0;
        wait_sig(0, 0, 10, c);
        check("t4_sample_us", 0, 32'(sus[0]), 32'd30);
        wait_sig(0, 1, 40, c);
        check("t4_sample_bcd", 0, 32'(sbcd[0]), 32'h000030);
        $display("tb: capture sample_us=%0d sample_bcd=%h", sus[0], sbcd[0]);

        // 5: edge coincides with the expiry condition on dut_b
        open_window(1);
        step(DIV * 101 - 3);
        sn[1] = 1'b0;
        wait_sig(1, 0, 10, c);
        check("t5_sample_us", 1, 32'(sus[1]), 32'd100);
        check("t5_no_timeout", 1, 32'(to[1]), 32'd0);
        wait_sig(1, 1, 40, c);
        check("t5_sample_bcd", 1, 32'(sbcd[1]), 32'h000100);
        check("t5_no_timeout_end", 1, 32'(to[1]), 32'd0);
        $display("tb: capture sample_us=%0d sample_bcd=%h", sus[1], sbcd[1]);
        rst[1] = 1'b1;

        // 6: capture of zero
        open_window(0);
        step(1);
        sn[0] = 1'b0;
        wait_sig(0, 0, 10, c);
        check("t6_sample_us", 0, 32'(sus[0]), 32'd0);
        wait_sig(0, 1, 40, c);
        check("t6_bcd_latency", 0, 32'(c), 32'd20);
        check("t6_sample_bcd", 0, 32'(sbcd[0]), 32'h000000);
        $display("tb: capture sample_us=%0d sample_bcd=%h", sus[0], sbcd[0]);

        // 7: reset 10 clocks into the conversion, then a fresh window
        open_window(0);
        step(DIV * 7);
        sn[0] = 1'b0;
        wait_sig(0, 0, 10, c);
        check("t7_sample_us", 0, 32'(sus[0]), 32'd7);
        step(10);
        rst[0] = 1'b1;
        #1;
        check("t7_rst_us_count", 0, 32'(usc[0]), 32'd0);
        check("t7_rst_sample_us", 0, 32'(sus[0]), 32'd0);
        check("t7_rst_sample_bcd", 0, 32'(sbcd[0]), 32'd0);
        check("t7_rst_bcd_valid", 0, 32'(bv[0]), 32'd0);
        check("t7_rst_busy", 0, 32'(bz[0]), 32'd1);
        step(25);
        sn[0] = 1'b1;
        step(2);
        rst[0] = 1'b0;
        step(DIV * 3);
        sn[0] = 1'b0;
        wait_sig(0, 0, 10, c);
        check("t7_fresh_sample_us", 0, 32'(sus[0]), 32'd3);
        wait_sig(0, 1, 40, c);
        check("t7_fresh_bcd", 0, 32'(sbcd[0]), 32'h000003);
        $display("tb: capture sample_us=%0d sample_bcd=%h", sus[0], sbcd[0]);

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit got=expired expected=finish");
        $fatal(1, "time limit");
    end

endmodule
